tx_arbiter: RTL and testbench

Packet-level arbiter that shares the single outbound link-layer stream among the five transaction-layer encoders: barrier, B, R, AR and AW+W. It is the transmit-side counterpart of the receive switch: each requester presents complete packets framed by `last`, and the arbiter forwards one whole packet at a time, never interleaving beats of different packets. Output is a registered stage feeding the link layer's `tx_*` handshake.

---
 rtl/tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_tx_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter
// Brief    : Packet-level arbiter sharing one registered tx stream among five
//            requesters (barrier, B, R, AR, AW+W); whole packets, no interleave.
// Revision : 1.0
// ============================================================================
module tx_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int BARRIER_PRIO = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [5*DATA_WIDTH*8-1:0]   in_data,
    input  logic [19:0]                 in_connection_id,
    input  logic [4:0]                  in_last,
    input  logic [4:0]                  in_valid,
    output logic [4:0]                  in_ready,
    output logic [DATA_WIDTH*8-1:0]     tx_data,
    output logic [3:0]                  tx_connection_id,
    output logic                        tx_last,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic [2:0]                  grant_id
);

    localparam int         c_BEAT_W  = DATA_WIDTH * 8;
    localparam int         c_NUM_REQ = 5;
    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_LOCK    = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [2:0]          r_last_grant;
    logic [2:0]          r_grant_id;
    logic                r_busy;
    logic [c_BEAT_W-1:0] r_tx_data;
    logic [3:0]          r_tx_cid;
    logic                r_tx_last;
    logic                r_tx_valid;

    logic [2:0]          w_winner;
    logic                w_any;
    logic [2:0]          w_sel;
    logic                w_sel_valid;
    logic                w_load_ok;
    logic                w_accept;
    logic [c_BEAT_W-1:0] w_data;
    logic [3:0]          w_cid;
    logic                w_last;

    // Index reached by stepping 'step' places past 'base', wrapping 4 -> 0.
    function automatic logic [2:0] f_rr_index(input logic [2:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= c_NUM_REQ) sum = sum - c_NUM_REQ;
        return 3'(sum);
    endfunction

    always_comb begin
        w_winner = 3'd0;
        w_any    = 1'b0;
        if (BARRIER_PRIO != 0 && in_valid[0]) begin
            w_any = 1'b1;
        end else begin
            for (int k = 1; k <= c_NUM_REQ; k++) begin
                if (!w_any && in_valid[f_rr_index(r_last_grant, k)]) begin
                    w_any    = 1'b1;
                    w_winner = f_rr_index(r_last_grant, k);
                end
            end
        end
    end

    always_comb begin
        w_load_ok = !r_tx_valid || tx_ready;
        if (r_state == c_LOCK) begin
            w_sel       = r_grant_id;
            w_sel_valid = in_valid[r_grant_id];
        end else begin
            w_sel       = w_winner;
            w_sel_valid = w_any;
        end
        w_accept = w_sel_valid && w_load_ok && !reset;

        in_ready = 5'b00000;
        if (!reset && (r_state == c_LOCK || w_any)) in_ready[w_sel] = w_load_ok;

        w_data = '0;
        w_cid  = 4'd0;
        w_last = 1'b0;
        for (int i = 0; i < c_NUM_REQ; i++) begin
            if (w_sel == 3'(i)) begin
                w_data = in_data[i*c_BEAT_W +: c_BEAT_W];
                w_cid  = in_connection_id[i*4 +: 4];
                w_last = in_last[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept && !w_last) w_state_nxt = c_LOCK;
            c_LOCK:  if (w_accept && w_last)  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Pointer resets to 4 so requester 0 is the first round-robin candidate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 3'd4;
            r_grant_id   <= 3'd0;
            r_busy       <= 1'b0;
        end else if (w_accept) begin
            r_grant_id <= w_sel;
            r_busy     <= !w_last;
            if (w_last) r_last_grant <= w_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_tx_cid   <= 4'd0;
            r_tx_last  <= 1'b0;
        end else if (w_accept) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_data;
            r_tx_cid   <= w_cid;
            r_tx_last  <= w_last;
        end else if (tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign tx_data          = r_tx_data;
    assign tx_connection_id = r_tx_cid;
    assign tx_last          = r_tx_last;
    assign tx_valid         = r_tx_valid;
    assign busy             = r_busy;
    assign grant_id         = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_arbiter
// Brief    : Self-checking bench for tx_arbiter (round-robin and barrier-priority
//            instances driven in parallel, one observed at a time).
// Revision : 1.0
// ============================================================================
module tb_tx_arbiter;

    localparam int DW = 16;
    localparam int W  = DW * 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [5*W-1:0] in_data;
    logic [19:0]    in_cid;
    logic [4:0]     in_last;
    logic [4:0]     in_valid;
    logic           tx_ready;

    logic [4:0]     rdy0, rdy1, rdy;
    logic [W-1:0]   txd0, txd1, txd;
    logic [3:0]     cid0, cid1, cid;
    logic           txl0, txl1, txl;
    logic           txv0, txv1, txv;
    logic           busy0, busy1, busy;
    logic [2:0]     gid0, gid1, gid;
    logic           sel;

    tx_arbiter #(.DATA_WIDTH(DW), .BARRIER_PRIO(0)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_connection_id(in_cid),
        .in_last(in_last), .in_valid(in_valid), .in_ready(rdy0),
        .tx_data(txd0), .tx_connection_id(cid0), .tx_last(txl0), .tx_valid(txv0),
        .tx_ready(tx_ready), .busy(busy0), .grant_id(gid0)
    );

    tx_arbiter #(.DATA_WIDTH(DW), .BARRIER_PRIO(1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_connection_id(in_cid),
        .in_last(in_last), .in_valid(in_valid), .in_ready(rdy1),
        .tx_data(txd1), .tx_connection_id(cid1), .tx_last(txl1), .tx_valid(txv1),
        .tx_ready(tx_ready), .busy(busy1), .grant_id(gid1)
    );

    assign rdy  = sel ? rdy1  : rdy0;
    assign txd  = sel ? txd1  : txd0;
    assign cid  = sel ? cid1  : cid0;
    assign txl  = sel ? txl1  : txl0;
    assign txv  = sel ? txv1  : txv0;
    assign busy = sel ? busy1 : busy0;
    assign gid  = sel ? gid1  : gid0;

    typedef struct packed {
        logic [W-1:0] data;
        logic [3:0]   cid;
        logic         last;
        logic [7:0]   gap;
    } beat_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic [3:0]   cid;
        logic         last;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [4:0] valid;
        logic [4:0] exp_rdy;
    } vec_t;

    beat_t        rq[5][$];
    exp_t         sb[$];
    int           waitc[5];
    logic [4:0]   acc;
    int           log_q[$];
    int           exp_q[$];
    int           txr_pat[$];
    int           cyc;
    int           ncyc;
    int           tests = 0;
    int           fails = 0;
    bit           prev_hold;
    logic [W-1:0] prev_data;
    logic [3:0]   prev_cid;
    logic         prev_last;
    vec_t         vecs[8];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_pkt(input int req, input int n, input int gap);
        beat_t t;
        for (int b = 0; b < n; b++) begin
            t.data      = {$urandom(), $urandom(), $urandom(), $urandom()};
            t.data[7:0] = 8'(req);
            t.cid       = 4'($urandom_range(0, 15));
            t.last      = (b == n - 1);
            t.gap       = (b == 0) ? 8'(gap) : 8'd0;
            rq[req].push_back(t);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 5; i++) begin
            if (rq[i].size() > 0 && waitc[i] == 0) begin
                in_valid[i]         = 1'b1;
                in_data[i*W +: W]   = rq[i][0].data;
                in_cid[i*4 +: 4]    = rq[i][0].cid;
                in_last[i]          = rq[i][0].last;
            end else begin
                in_valid[i] = 1'b0;
                in_last[i]  = 1'b0;
            end
        end
        tx_ready = (txr_pat.size() > 0) ? (txr_pat[cyc % txr_pat.size()] != 0) : 1'b1;
    endtask

    task automatic start();
        for (int i = 0; i < 5; i++) waitc[i] = (rq[i].size() > 0) ? int'(rq[i][0].gap) : 0;
        cyc       = 0;
        prev_hold = 1'b0;
        drive();
    endtask

    task automatic reset_all();
        reset    = 1'b1;
        in_valid = 5'd0;
        in_last  = 5'd0;
        in_data  = '0;
        in_cid   = '0;
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) rq[i].delete();
        sb.delete();
        log_q.delete();
        exp_q.delete();
        txr_pat.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Called at the falling edge: inputs and combinational ready are settled.
    task automatic sample();
        exp_t e;
        acc = in_valid & rdy;
        chk_i("ready_onehot", int'($onehot0(rdy)), 1);
        if (rdy != 5'd0) chk_i("ready_needs_load_ok", int'(!txv || tx_ready), 1);
        for (int i = 0; i < 5; i++) begin
            if (acc[i]) begin
                e.data = rq[i][0].data;
                e.cid  = rq[i][0].cid;
                e.last = rq[i][0].last;
                sb.push_back(e);
            end
        end
        if (prev_hold) begin
            chk_i("hold_valid", int'(txv), 1);
            chk("hold_data", txd, prev_data);
            chk_i("hold_cid", int'(cid), int'(prev_cid));
            chk_i("hold_last", int'(txl), int'(prev_last));
        end
        if (txv && tx_ready) begin
            if (sb.size() == 0) begin
                chk_i("unexpected_beat", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("tx_data", txd, e.data);
                chk_i("tx_cid", int'(cid), int'(e.cid));
                chk_i("tx_last", int'(txl), int'(e.last));
                chk_i("busy_while_locked", int'(busy), int'(!txl));
                chk_i("grant_id", int'(gid), int'(txd[2:0]));
                log_q.push_back(int'(txd[7:0]));
            end
        end
        prev_hold = txv && !tx_ready;
        prev_data = txd;
        prev_cid  = cid;
        prev_last = txl;
    endtask

    task automatic advance();
        for (int i = 0; i < 5; i++) begin
            if (acc[i]) begin
                void'(rq[i].pop_front());
                waitc[i] = (rq[i].size() > 0) ? int'(rq[i][0].gap) : 0;
            end else if (!in_valid[i] && waitc[i] > 0) begin
                waitc[i]--;
            end
        end
        cyc++;
        drive();
    endtask

    function automatic bit drained();
        bit d;
        d = (sb.size() == 0);
        for (int i = 0; i < 5; i++) if (rq[i].size() > 0) d = 1'b0;
        return d;
    endfunction

    task automatic run(input int max_cycles, input bit need_drain);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            sample();
            @(posedge clk);
            #1;
            advance();
            n++;
            done = (n >= max_cycles) || (need_drain && drained());
        end
        if (need_drain && !drained()) chk_i("drain_timeout", n, -1);
        ncyc = n;
    endtask

    task automatic check_order(input string name);
        chk_i({name, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk_i($sformatf("%s_beat%0d", name, i), log_q[i], exp_q[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        sel = 1'b0;
        vecs[0] = '{1'b0, 5'b00000, 5'b00000};
        vecs[1] = '{1'b0, 5'b00001, 5'b00001};
        vecs[2] = '{1'b0, 5'b00110, 5'b00010};
        vecs[3] = '{1'b0, 5'b11000, 5'b01000};
        vecs[4] = '{1'b0, 5'b10000, 5'b10000};
        vecs[5] = '{1'b0, 5'b11111, 5'b00001};
        vecs[6] = '{1'b1, 5'b11111, 5'b00000};
        vecs[7] = '{1'b1, 5'b00100, 5'b00000};

        reset_all();
        chk_i("rst_tx_valid", int'(txv0), 0);
        chk("rst_tx_data", txd0, '0);
        chk_i("rst_tx_cid", int'(cid0), 0);
        chk_i("rst_tx_last", int'(txl0), 0);
        chk_i("rst_busy", int'(busy0), 0);
        chk_i("rst_grant_id", int'(gid0), 0);
        chk_i("rst_tx_valid_prio", int'(txv1), 0);

        // Combinational arbitration from the reset pointer; valid dropped before each edge.
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            reset    = vecs[k].rst;
            in_valid = vecs[k].valid;
            #3;
            chk_i($sformatf("tbl%0d_ready_rr", k), int'(rdy0), int'(vecs[k].exp_rdy));
            chk_i($sformatf("tbl%0d_ready_prio", k), int'(rdy1), int'(vecs[k].exp_rdy));
            #2;
            in_valid = 5'd0;
            reset    = 1'b0;
        end

        // Single-beat fairness under round-robin.
        reset_all();
        sel = 1'b0;
        for (int i = 0; i < 5; i++) for (int p = 0; p < 20; p++) add_pkt(i, 1, 0);
        for (int p = 0; p < 20; p++) for (int i = 0; i < 5; i++) exp_q.push_back(i);
        start();
        run(300, 1'b1);
        check_order("fair");
        chk_i("fair_cycles", ncyc, 101);

        // Packet lock: requester 4 owns the link for five beats while 2 waits.
        reset_all();
        add_pkt(4, 5, 0);
        add_pkt(2, 1, 1);
        exp_q = '{4, 4, 4, 4, 4, 2};
        start();
        run(50, 1'b1);
        check_order("lock");
        chk_i("lock_cycles", ncyc, 7);

        // Barrier priority with single-beat traffic against requester 3.
        reset_all();
        sel = 1'b1;
        add_pkt(0, 1, 0);
        add_pkt(0, 1, 0);
        add_pkt(0, 1, 2);
        add_pkt(0, 1, 0);
        for (int p = 0; p < 3; p++) add_pkt(3, 1, 0);
        exp_q = '{0, 0, 3, 3, 0, 0, 3};
        start();
        run(50, 1'b1);
        check_order("barrier");

        // Barrier raised during a locked R packet waits for its last beat.
        reset_all();
        add_pkt(2, 4, 0);
        add_pkt(0, 1, 1);
        exp_q = '{2, 2, 2, 2, 0};
        start();
        run(50, 1'b1);
        check_order("barrier_wait");

        // Backpressure pattern during a 3-beat packet.
        reset_all();
        sel = 1'b0;
        add_pkt(1, 3, 0);
        txr_pat = '{1, 0, 0, 1};
        exp_q   = '{1, 1, 1};
        start();
        run(50, 1'b1);
        check_order("backpressure");

        // Granted requester stalls for three cycles mid-packet.
        reset_all();
        add_pkt(3, 3, 0);
        begin
            beat_t t;
            t = rq[3][1];
            t.gap = 8'd3;
            rq[3][1] = t;
        end
        add_pkt(1, 1, 1);
        add_pkt(4, 1, 1);
        exp_q = '{3, 3, 3, 4, 1};
        start();
        run(50, 1'b1);
        check_order("stall");

        // Reset while beat 2 of a 4-beat packet is on the link.
        reset_all();
        add_pkt(0, 1, 0);
        add_pkt(2, 4, 1);
        exp_q = '{0, 2};
        start();
        run(3, 1'b0);
        check_order("pre_reset");
        chk_i("pre_reset_tx_valid", int'(txv), 1);
        chk_i("pre_reset_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk_i("reset_tx_valid_drop", int'(txv), 0);
        chk_i("reset_ready_zero", int'(rdy), 0);
        chk_i("reset_busy_clear", int'(busy), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) rq[i].delete();
        sb.delete();
        log_q.delete();
        reset = 1'b0;
        add_pkt(1, 1, 0);
        add_pkt(0, 1, 0);
        exp_q = '{0, 1};
        start();
        run(50, 1'b1);
        check_order("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
